// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves one conditional branch per handshake, redirects the PC and
// flushes IF/ID on a mispredict. Define BHT_EN to build the 2-bit branch history table.
module branch_ctrl #(
  parameter int BHT_IDX_W    = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_imm,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        req_pred,
  output logic        res_valid,
  output logic        res_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RESOLVE = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  // Branch comparator; reserved func3 encodings resolve not-taken.
  function automatic logic branch_cmp(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    logic t;
    t = 1'b0;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) <  $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a <  b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic [1:0]  r_state;
  logic [3:0]  r_flush_cnt;
  logic        r_mis;
  logic        w_accept;
  logic        w_taken;
  logic        w_pred;
  logic        w_mis;
  logic [31:0] w_target;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_taken  = branch_cmp(req_func3, req_rs1, req_rs2);
  assign w_mis    = w_taken ^ w_pred;
  assign w_target = w_taken ? (req_pc + req_imm) : (req_pc + 32'd4);

  // Sequencer; resolution results are registered at the accept edge so they
  // are presented from the RESOLVE cycle straight out of flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_flush_cnt    <= 4'd0;
      r_mis          <= 1'b0;
      req_ready      <= 1'b1;
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      flush          <= 1'b0;
    end else begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state        <= S_RESOLVE;
            r_mis          <= w_mis;
            req_ready      <= 1'b0;
            res_valid      <= 1'b1;
            res_taken      <= w_taken;
            redirect_valid <= w_mis;
            redirect_pc    <= w_target;
            flush          <= w_mis;
          end
        end
        S_RESOLVE: begin
          if (r_mis) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= FLUSH_LOAD;
            flush       <= 1'b1;
          end else begin
            r_state   <= S_IDLE;
            req_ready <= 1'b1;
            flush     <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            r_state   <= S_IDLE;
            req_ready <= 1'b1;
            flush     <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
          flush     <= 1'b0;
        end
      endcase
    end
  end

  // Statistics, updated at the edge that ends RESOLVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count   <= 32'd0;
      miss_count <= 32'd0;
    end else if (r_state == S_RESOLVE) begin
      br_count <= br_count + 32'd1;
      if (r_mis) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

`ifdef BHT_EN
  localparam int BHT_DEPTH = 1 << BHT_IDX_W;

  logic [1:0]           r_bht [BHT_DEPTH];
  logic [BHT_IDX_W-1:0] r_bht_idx;
  logic                 w_unused;

  assign w_pred     = req_pred;
  assign pred_taken = r_bht[pred_pc[BHT_IDX_W+1:2]][1];
  assign w_unused   = ^{pred_pc[31:BHT_IDX_W+2], pred_pc[1:0]};

  // Saturating-counter update; lookups in the same cycle see the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= 2'b01;
      end
      r_bht_idx <= {BHT_IDX_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_bht_idx <= req_pc[BHT_IDX_W+1:2];
      end
      if (r_state == S_RESOLVE) begin
        if (res_taken && (r_bht[r_bht_idx] != 2'b11)) begin
          r_bht[r_bht_idx] <= r_bht[r_bht_idx] + 2'b01;
        end else if (!res_taken && (r_bht[r_bht_idx] != 2'b00)) begin
          r_bht[r_bht_idx] <= r_bht[r_bht_idx] - 2'b01;
        end
      end
    end
  end
`else
  logic w_unused;

  // Static not-taken: every taken branch mispredicts.
  assign w_pred     = 1'b0;
  assign pred_taken = 1'b0;
  assign w_unused   = ^{pred_pc, req_pred};
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed cases plus randomized branches
// against a behavioural model of outcome, redirect timing, counters and BHT.
module tb_branch_ctrl;
  localparam int IDX_W = 6;
  localparam int FC    = 2;
  localparam int DEPTH = 64;
`ifdef BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_func3 = 3'd0;
  logic [31:0] req_pc = 32'd0;
  logic [31:0] req_imm = 32'd0;
  logic [31:0] req_rs1 = 32'd0;
  logic [31:0] req_rs2 = 32'd0;
  logic        req_pred = 1'b0;
  logic        res_valid;
  logic        res_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] pred_pc = 32'd0;
  logic        pred_taken;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  int n_total = 0;
  int n_pass  = 0;
  int m_br    = 0;
  int m_miss  = 0;
  int m_bht[DEPTH];

  always #5 clk = ~clk;

  branch_ctrl #(.BHT_IDX_W(IDX_W), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_func3(req_func3), .req_pc(req_pc), .req_imm(req_imm),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pred(req_pred),
    .res_valid(res_valid), .res_taken(res_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .br_count(br_count), .miss_count(miss_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit model_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return longint'(a) < longint'(b);
      3'd7:    return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_br   = 0;
    m_miss = 0;
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
  endtask

  task automatic do_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] a, input logic [31:0] b, input logic pred,
                           input bit hold);
    bit          tk, mis;
    logic [31:0] exp_pc;
    longint      sum;
    int          idx, old;
    for (int w = 0; w < 50 && req_ready !== 1'b1; w++) tick();
    check("ready_wait", req_ready, 32'd1);
    tk  = model_taken(f3, a, b);
    mis = (tk != (BHT_ON ? pred : 1'b0));
    sum = tk ? (longint'(pc) + longint'(imm)) : (longint'(pc) + 64'd4);
    exp_pc = sum[31:0];
    idx = int'((pc / 4) % DEPTH);
    old = m_bht[idx];
    req_func3 = f3; req_pc = pc; req_imm = imm;
    req_rs1 = a; req_rs2 = b; req_pred = pred; req_valid = 1'b1;
    tick();
    check("res_valid", res_valid, 32'd1);
    check("res_taken", res_taken, tk);
    check("redirect_valid", redirect_valid, mis);
    check("flush_resolve", flush, mis);
    check("ready_resolve", req_ready, 32'd0);
    if (mis) check("redirect_pc", redirect_pc, exp_pc);
    pred_pc = pc;
    #1;
    check("bht_rbw", pred_taken, BHT_ON && (old >= 2));
    req_valid = hold;
    m_br++;
    if (mis) m_miss++;
    m_bht[idx] = tk ? ((old < 3) ? old + 1 : 3) : ((old > 0) ? old - 1 : 0);
    for (int k = 0; k < (mis ? FC : 0); k++) begin
      tick();
      check("flush_hold", flush, 32'd1);
      check("ready_flush", req_ready, 32'd0);
      check("res_valid_once", res_valid, 32'd0);
      check("redirect_once", redirect_valid, 32'd0);
    end
    tick();
    req_valid = 1'b0;
    check("ready_back", req_ready, 32'd1);
    check("flush_end", flush, 32'd0);
    check("res_valid_end", res_valid, 32'd0);
    check("br_count", br_count, m_br);
    check("miss_count", miss_count, m_miss);
    #1;
    check("bht_upd", pred_taken, BHT_ON && (m_bht[idx] >= 2));
  endtask

  initial begin
    logic [31:0] r_pc, r_a, r_b, r_imm;
    model_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", req_ready, 32'd1);
    check("rst_res_valid", res_valid, 32'd0);
    check("rst_redirect", redirect_valid, 32'd0);
    check("rst_flush", flush, 32'd0);
    check("rst_br", br_count, 32'd0);
    check("rst_miss", miss_count, 32'd0);
    check("rst_pred", pred_taken, 32'd0);
    rst = 1'b0;
    tick();

    // BEQ taken vs not-taken prediction, with req_valid held through RESOLVE/FLUSH
    do_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 1'b1);
    do_branch(3'b100, 32'h200, 32'h40, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    do_branch(3'b110, 32'h204, 32'h40, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    do_branch(3'b000, 32'hFFFFFFFC, 32'h80, 32'd1, 32'd2, 1'b1, 1'b0);
    do_branch(3'b000, 32'h10, 32'hFFFFFFE0, 32'd3, 32'd3, 1'b0, 1'b0);
    do_branch(3'b010, 32'h300, 32'h8, 32'd9, 32'd9, 1'b0, 1'b1);
    do_branch(3'b011, 32'h304, 32'h8, 32'd1, 32'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_branch(3'b000, 32'h40, 32'h100, 32'd1, 32'd1, 1'b1, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      r_pc  = $urandom() & 32'hFFFFFFFC;
      r_imm = $urandom() & 32'hFFFFFFFE;
      r_a   = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 8));
      r_b   = ($urandom_range(0, 2) == 0) ? r_a : (($urandom_range(0, 1) == 0) ?
              $urandom() : 32'($urandom_range(0, 8)));
      do_branch(3'($urandom_range(0, 7)), r_pc, r_imm, r_a, r_b,
                1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // Reset asserted while flushing
    req_func3 = 3'b000; req_pc = 32'h200; req_imm = 32'h8;
    req_rs1 = 32'd7; req_rs2 = 32'd7; req_pred = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_rst_flush", flush, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_flush_clr", flush, 32'd0);
    check("rst_ready_set", req_ready, 32'd1);
    check("rst_br_clr", br_count, 32'd0);
    check("rst_miss_clr", miss_count, 32'd0);
    check("rst_resv_clr", res_valid, 32'd0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      pred_pc = 32'(i * 4);
      #1;
      check("rst_bht", pred_taken, 32'd0);
    end
    tick();
    do_branch(3'b101, 32'h80, 32'h10, 32'd4, 32'd4, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
